// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: arbitrates exc > ex_br > pd_br redirects, parks them across stalls, sequences IDLE.
// Latency: redirect lands in pc_IF1 one cycle after the unstalled request; pc_IF1 holds while stall_icache|stall_ib.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          EPOCH_W  = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [31:0]        pc_predict,
    input  logic               exc_valid,
    input  logic [31:0]        exc_pc,
    input  logic               ex_br,
    input  logic [31:0]        ex_br_pc,
    input  logic               pd_br,
    input  logic [31:0]        pd_br_pc,
    input  logic               idle_req,
    input  logic [31:0]        idle_pc,
    input  logic               stall_icache,
    input  logic               stall_ib,
    output logic [31:0]        pc_IF1,
    output logic               is_valid,
    output logic               flush_front,
    output logic [EPOCH_W-1:0] fetch_epoch
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    localparam logic [1:0] PRI_EXC = 2'd2;
    localparam logic [1:0] PRI_EX  = 2'd1;
    localparam logic [1:0] PRI_PD  = 2'd0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        w_pc_nxt;
    logic [31:0]        r_pend_pc;
    logic [31:0]        w_pend_pc_nxt;
    logic [1:0]         r_pend_pri;
    logic [1:0]         w_pend_pri_nxt;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_rel;

    logic               w_stall;
    logic               w_win_vld;
    logic [1:0]         w_win_pri;
    logic [31:0]        w_win_pc;
    logic               w_win_ge;
    logic               w_flush;

    assign w_stall = stall_icache | stall_ib;

    always_comb begin
        w_win_vld = 1'b0;
        w_win_pri = PRI_PD;
        w_win_pc  = pd_br_pc;
        if (exc_valid) begin
            w_win_vld = 1'b1;
            w_win_pri = PRI_EXC;
            w_win_pc  = exc_pc;
        end else if (ex_br) begin
            w_win_vld = 1'b1;
            w_win_pri = PRI_EX;
            w_win_pc  = ex_br_pc;
        end else if (pd_br) begin
            w_win_vld = 1'b1;
        end
    end

    // Equal priority replaces the parked entry so the youngest redirect survives.
    assign w_win_ge = w_win_vld && (w_win_pri >= r_pend_pri);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_pc_nxt  = r_pend_pc;
        w_pend_pri_nxt = r_pend_pri;
        case (r_state)
            ST_RUN: begin
                if (idle_req && !exc_valid) begin
                    w_pc_nxt    = idle_pc;
                    w_state_nxt = ST_IDLE;
                end else if (w_win_vld) begin
                    if (w_stall) begin
                        w_pend_pc_nxt  = w_win_pc;
                        w_pend_pri_nxt = w_win_pri;
                        w_state_nxt    = ST_HOLD;
                    end else begin
                        w_pc_nxt = w_win_pc;
                    end
                end else if (!w_stall) begin
                    w_pc_nxt = pc_predict;
                end
            end
            ST_HOLD: begin
                if (w_stall) begin
                    if (w_win_ge) begin
                        w_pend_pc_nxt  = w_win_pc;
                        w_pend_pri_nxt = w_win_pri;
                    end
                end else begin
                    w_pc_nxt    = w_win_ge ? w_win_pc : r_pend_pc;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_IDLE: begin
                // Wake does not wait for the stall: nothing is being looked up while idle.
                if (exc_valid) begin
                    w_pc_nxt    = exc_pc;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_flush = exc_valid | (ex_br & (r_state != ST_IDLE));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_pend_pc  <= 32'd0;
            r_pend_pri <= PRI_PD;
            r_epoch    <= '0;
            r_rel      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_pend_pri <= w_pend_pri_nxt;
            r_rel      <= 1'b1;
            if (w_flush) begin
                r_epoch <= r_epoch + EPOCH_W'(1);
            end
        end
    end

    assign pc_IF1      = r_pc;
    assign fetch_epoch = r_epoch;
    assign flush_front = w_flush;
    assign is_valid    = (r_state == ST_RUN) & ~w_stall & ~exc_valid & ~ex_br & ~pd_br
                       & ~idle_req & r_rel;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: expectations queued per cycle, checked on the falling edge.
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        rstn;
    logic [31:0] pc_predict;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        ex_br;
    logic [31:0] ex_br_pc;
    logic        pd_br;
    logic [31:0] pd_br_pc;
    logic        idle_req;
    logic [31:0] idle_pc;
    logic        stall_icache;
    logic        stall_ib;
    logic [31:0] pc_IF1;
    logic        is_valid;
    logic        flush_front;
    logic [1:0]  fetch_epoch;

    fetch_redirect_ctrl #(
        .RESET_PC (32'h1c00_0000),
        .EPOCH_W  (2)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pc_predict   (pc_predict),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .ex_br        (ex_br),
        .ex_br_pc     (ex_br_pc),
        .pd_br        (pd_br),
        .pd_br_pc     (pd_br_pc),
        .idle_req     (idle_req),
        .idle_pc      (idle_pc),
        .stall_icache (stall_icache),
        .stall_ib     (stall_ib),
        .pc_IF1       (pc_IF1),
        .is_valid     (is_valid),
        .flush_front  (flush_front),
        .fetch_epoch  (fetch_epoch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        vld;
        logic        flush;
        logic [1:0]  ep;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Expected outputs for the current cycle; predictor keeps pointing at the next sequential PC.
    task automatic push_exp(input string tag, input logic [31:0] pc, input logic vld,
                            input logic flush, input logic [1:0] ep);
        exp_t e;
        e.tag   = tag;
        e.pc    = pc;
        e.vld   = vld;
        e.flush = flush;
        e.ep    = ep;
        sb_q.push_back(e);
        pc_predict = pc + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exc_valid    = 1'b0;
        ex_br        = 1'b0;
        pd_br        = 1'b0;
        idle_req     = 1'b0;
        stall_icache = 1'b0;
        stall_ib     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            e_cur = sb_q.pop_front();
            chk({e_cur.tag, ".pc"},    pc_IF1,             e_cur.pc);
            chk({e_cur.tag, ".vld"},   {31'd0, is_valid},    {31'd0, e_cur.vld});
            chk({e_cur.tag, ".flush"}, {31'd0, flush_front}, {31'd0, e_cur.flush});
            chk({e_cur.tag, ".epoch"}, {30'd0, fetch_epoch}, {30'd0, e_cur.ep});
        end
    end

    initial begin
        rstn         = 1'b0;
        pc_predict   = 32'h1c00_0004;
        exc_valid    = 1'b0;
        exc_pc       = 32'd0;
        ex_br        = 1'b0;
        ex_br_pc     = 32'd0;
        pd_br        = 1'b0;
        pd_br_pc     = 32'd0;
        idle_req     = 1'b0;
        idle_pc      = 32'd0;
        stall_icache = 1'b0;
        stall_ib     = 1'b0;
        @(posedge clk);
        #1;

        // reset and free run
        push_exp("rst", 32'h1c00_0000, 1'b0, 1'b0, 2'd0); tick();
        rstn = 1'b1;
        push_exp("run0", 32'h1c00_0000, 1'b0, 1'b0, 2'd0); tick();
        push_exp("run1", 32'h1c00_0004, 1'b1, 1'b0, 2'd0); tick();
        push_exp("run2", 32'h1c00_0008, 1'b1, 1'b0, 2'd0); tick();

        // pd_br parked during a 3-cycle icache stall
        stall_icache = 1'b1; pd_br = 1'b1; pd_br_pc = 32'h1c00_0100;
        push_exp("hpd_a", 32'h1c00_000c, 1'b0, 1'b0, 2'd0); tick();
        stall_icache = 1'b1;
        push_exp("hpd_b", 32'h1c00_000c, 1'b0, 1'b0, 2'd0); tick();
        stall_icache = 1'b1;
        push_exp("hpd_c", 32'h1c00_000c, 1'b0, 1'b0, 2'd0); tick();
        push_exp("hpd_rel", 32'h1c00_000c, 1'b0, 1'b0, 2'd0); tick();
        push_exp("hpd_tgt", 32'h1c00_0100, 1'b1, 1'b0, 2'd0); tick();

        // parked pd_br overwritten by ex_br; lower-priority pd_br at release ignored
        stall_icache = 1'b1; pd_br = 1'b1; pd_br_pc = 32'h1c00_0180;
        push_exp("ovr_a", 32'h1c00_0104, 1'b0, 1'b0, 2'd0); tick();
        stall_icache = 1'b1; ex_br = 1'b1; ex_br_pc = 32'h1c00_0200;
        push_exp("ovr_ex", 32'h1c00_0104, 1'b0, 1'b1, 2'd0); tick();
        stall_icache = 1'b1;
        push_exp("ovr_b", 32'h1c00_0104, 1'b0, 1'b0, 2'd1); tick();
        pd_br = 1'b1; pd_br_pc = 32'h1c00_0300;
        push_exp("ovr_rel", 32'h1c00_0104, 1'b0, 1'b0, 2'd1); tick();
        push_exp("ovr_tgt", 32'h1c00_0200, 1'b1, 1'b0, 2'd1); tick();

        // all three sources at once
        exc_valid = 1'b1; exc_pc = 32'h1c00_8000;
        ex_br = 1'b1; ex_br_pc = 32'h1c00_0400;
        pd_br = 1'b1; pd_br_pc = 32'h1c00_0500;
        push_exp("tri", 32'h1c00_0204, 1'b0, 1'b1, 2'd1); tick();
        push_exp("tri_tgt", 32'h1c00_8000, 1'b1, 1'b0, 2'd2); tick();

        // IDLE: stalls, repeat idle_req and ex_br are all ignored; exc wakes
        idle_req = 1'b1; idle_pc = 32'h1c00_0040;
        push_exp("idle_req", 32'h1c00_8004, 1'b0, 1'b0, 2'd2); tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                idle_req = 1'b1; idle_pc = 32'h1c00_0990; stall_ib = 1'b1;
            end
            push_exp("idle_wait", 32'h1c00_0040, 1'b0, 1'b0, 2'd2); tick();
        end
        ex_br = 1'b1; ex_br_pc = 32'h1c00_0600;
        push_exp("idle_exbr", 32'h1c00_0040, 1'b0, 1'b0, 2'd2); tick();
        exc_valid = 1'b1; exc_pc = 32'h1c00_8000; stall_icache = 1'b1;
        push_exp("idle_wake", 32'h1c00_0040, 1'b0, 1'b1, 2'd2); tick();
        push_exp("wake_tgt", 32'h1c00_8000, 1'b1, 1'b0, 2'd3); tick();

        // exc together with idle_req: IDLE not entered; epoch wraps 3->0
        exc_valid = 1'b1; exc_pc = 32'h1c00_9000; idle_req = 1'b1; idle_pc = 32'h1c00_0040;
        push_exp("exc_idle", 32'h1c00_8004, 1'b0, 1'b1, 2'd3); tick();
        push_exp("exc_idle_tgt", 32'h1c00_9000, 1'b1, 1'b0, 2'd0); tick();

        // four back-to-back ex_br: epoch 0,1,2,3 then 0
        for (int i = 0; i < 4; i++) begin
            ex_br    = 1'b1;
            ex_br_pc = 32'h1c00_a000 + 32'(i) * 32'h100;
            push_exp("wrap", (i == 0) ? 32'h1c00_9004 : 32'h1c00_a000 + 32'(i - 1) * 32'h100,
                     1'b0, 1'b1, 2'(i));
            tick();
        end
        push_exp("wrap_end", 32'h1c00_a300, 1'b1, 1'b0, 2'd0); tick();

        // reset while an exc is parked in HOLD: pending entry must be lost
        stall_ib = 1'b1; exc_valid = 1'b1; exc_pc = 32'h1c00_b000;
        push_exp("hrst_a", 32'h1c00_a304, 1'b0, 1'b1, 2'd0); tick();
        stall_ib = 1'b1;
        push_exp("hrst_b", 32'h1c00_a304, 1'b0, 1'b0, 2'd1); tick();
        rstn = 1'b0;
        push_exp("hrst_rst", 32'h1c00_0000, 1'b0, 1'b0, 2'd0); tick();
        rstn = 1'b1;
        push_exp("hrst_rel", 32'h1c00_0000, 1'b0, 1'b0, 2'd0); tick();
        push_exp("hrst_run", 32'h1c00_0004, 1'b1, 1'b0, 2'd0); tick();

        for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        chk("drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
